// File: rtl/decoder_3lanpc_multi.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3lanpc_multi
// Description : Multi-leg 3-level ANPC gate decoder. Each leg turns a 2-bit
//               level request into six gate signals, with overlap dead-time,
//               a forced zero dwell on P<->N, selectable O+/O- zero paths and a
//               shared sticky trip that turns every gate off.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3lanpc_multi #(
    parameter int N_LEGS       = 3,
    parameter int TDELAY_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TDELAY_WIDTH-1:0]   t_dead,
    input  logic [TDELAY_WIDTH-1:0]   t_zmin,
    input  logic [2*N_LEGS-1:0]       v_lev,
    input  logic [N_LEGS-1:0]         zero_sel,
    input  logic                      trip,
    input  logic                      trip_clr,
    output logic [6*N_LEGS-1:0]       S_out,
    output logic [N_LEGS-1:0]         busy,
    output logic                      faulted,
    output logic [N_LEGS-1:0]         illegal_req
);

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        DEAD   = 2'd1,
        ZDWELL = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam logic [1:0] c_lev_zero = 2'b00;
    localparam logic [1:0] c_lev_p    = 2'b01;
    localparam logic [1:0] c_lev_n    = 2'b10;
    localparam logic [1:0] c_lev_bad  = 2'b11;

    localparam logic [TDELAY_WIDTH-1:0] c_cnt_one = {{(TDELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TDELAY_WIDTH-1:0] c_cnt_max = {TDELAY_WIDTH{1'b1}};

    // Gate pattern {S6..S1} for a level; the zero level depends on its path.
    function automatic logic [5:0] pat(input logic [1:0] lev, input logic zs);
        case (lev)
            c_lev_p:    pat = 6'b100011;
            c_lev_n:    pat = 6'b011100;
            c_lev_zero: pat = zs ? 6'b100100 : 6'b010010;
            default:    pat = 6'b000000;
        endcase
    endfunction

    // Terminal counts: a zero interval behaves as one cycle.
    logic [TDELAY_WIDTH-1:0] dead_lim;
    logic [TDELAY_WIDTH-1:0] zmin_lim;
    assign dead_lim = (t_dead == '0) ? '0 : (t_dead - c_cnt_one);
    assign zmin_lim = (t_zmin == '0) ? '0 : (t_zmin - c_cnt_one);

    // Shared fault latch and the "just released from reset" marker.
    logic faulted_d, faulted_q;
    logic init_d, init_q;

    // Trip sets the latch and wins over a clear; a clear only works with trip low.
    always_comb begin
        faulted_d = faulted_q;
        init_d    = 1'b0;
        if (trip) begin
            faulted_d = 1'b1;
        end else if (trip_clr) begin
            faulted_d = 1'b0;
        end
    end

    // Shared flops; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            faulted_q <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            faulted_q <= faulted_d;
            init_q    <= init_d;
        end
    end

    assign faulted = faulted_q;

    generate
        for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
            state_e                  state_d, state_q;
            logic [1:0]              cur_lev_d, cur_lev_q;
            logic                    cur_zsel_d, cur_zsel_q;
            logic [1:0]              tgt_lev_d, tgt_lev_q;
            logic                    tgt_zsel_d, tgt_zsel_q;
            logic [1:0]              final_lev_d, final_lev_q;
            logic                    final_pend_d, final_pend_q;
            logic [TDELAY_WIDTH-1:0] cnt_d, cnt_q;
            logic [TDELAY_WIDTH-1:0] lim_d, lim_q;
            logic [5:0]              s_d, s_q;
            logic                    busy_d, busy_q;
            logic                    illegal_d, illegal_q;

            logic [1:0]              req;
            logic                    zs;
            logic                    cnt_done;
            logic [TDELAY_WIDTH-1:0] cnt_inc;
            logic [1:0]              start_tgt;
            logic                    start_pn;

            assign req      = v_lev[2*i +: 2];
            assign zs       = zero_sel[i];
            assign cnt_done = (cnt_q == lim_q);
            assign cnt_inc  = (cnt_q == c_cnt_max) ? cnt_q : (cnt_q + c_cnt_one);
            assign start_pn = ((cur_lev_q == c_lev_p) && (req == c_lev_n)) ||
                              ((cur_lev_q == c_lev_n) && (req == c_lev_p));
            assign start_tgt = start_pn ? c_lev_zero : req;

            // Next-state, next-gates and interval timing for this leg.
            always_comb begin
                state_d      = state_q;
                cur_lev_d    = cur_lev_q;
                cur_zsel_d   = cur_zsel_q;
                tgt_lev_d    = tgt_lev_q;
                tgt_zsel_d   = tgt_zsel_q;
                final_lev_d  = final_lev_q;
                final_pend_d = final_pend_q;
                cnt_d        = cnt_q;
                lim_d        = lim_q;
                s_d          = s_q;
                busy_d       = busy_q;
                illegal_d    = 1'b0;

                if (trip) begin
                    state_d      = FAULT;
                    s_d          = 6'b000000;
                    busy_d       = 1'b0;
                    final_pend_d = 1'b0;
                end else begin
                    case (state_q)
                        STEADY: begin
                            busy_d = 1'b0;
                            if (req == c_lev_bad) begin
                                illegal_d = 1'b1;
                            end else if ((req != cur_lev_q) ||
                                         ((cur_lev_q == c_lev_zero) && (zs != cur_zsel_q))) begin
                                tgt_lev_d    = start_tgt;
                                tgt_zsel_d   = zs;
                                final_lev_d  = req;
                                final_pend_d = start_pn;
                                s_d          = pat(cur_lev_q, cur_zsel_q) & pat(start_tgt, zs);
                                state_d      = DEAD;
                                cnt_d        = '0;
                                lim_d        = dead_lim;
                                busy_d       = 1'b1;
                            end
                        end
                        DEAD: begin
                            if (init_q) begin
                                // First edge out of reset opens the interval.
                                cnt_d  = '0;
                                lim_d  = dead_lim;
                                busy_d = 1'b1;
                            end else if (cnt_done) begin
                                cur_lev_d  = tgt_lev_q;
                                cur_zsel_d = tgt_zsel_q;
                                s_d        = pat(tgt_lev_q, tgt_zsel_q);
                                if (final_pend_q) begin
                                    state_d = ZDWELL;
                                    cnt_d   = '0;
                                    lim_d   = zmin_lim;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = STEADY;
                                    busy_d  = 1'b0;
                                end
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                        ZDWELL: begin
                            if (cnt_done) begin
                                tgt_lev_d    = final_lev_q;
                                final_pend_d = 1'b0;
                                s_d          = pat(cur_lev_q, cur_zsel_q) & pat(final_lev_q, 1'b0);
                                state_d      = DEAD;
                                cnt_d        = '0;
                                lim_d        = dead_lim;
                                busy_d       = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                        default: begin
                            // FAULT: recover through an all-off interval to zero.
                            busy_d = 1'b0;
                            if (trip_clr) begin
                                state_d      = DEAD;
                                s_d          = 6'b000000;
                                tgt_lev_d    = c_lev_zero;
                                tgt_zsel_d   = zs;
                                final_pend_d = 1'b0;
                                cnt_d        = '0;
                                lim_d        = dead_lim;
                                busy_d       = 1'b1;
                            end
                        end
                    endcase
                end
            end

            // Leg registers; reset parks the leg in an all-off interval toward zero.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_q      <= DEAD;
                    cur_lev_q    <= c_lev_zero;
                    cur_zsel_q   <= 1'b0;
                    tgt_lev_q    <= c_lev_zero;
                    tgt_zsel_q   <= zs;
                    final_lev_q  <= c_lev_zero;
                    final_pend_q <= 1'b0;
                    cnt_q        <= '0;
                    lim_q        <= dead_lim;
                    s_q          <= 6'b000000;
                    busy_q       <= 1'b0;
                    illegal_q    <= 1'b0;
                end else begin
                    state_q      <= state_d;
                    cur_lev_q    <= cur_lev_d;
                    cur_zsel_q   <= cur_zsel_d;
                    tgt_lev_q    <= tgt_lev_d;
                    tgt_zsel_q   <= tgt_zsel_d;
                    final_lev_q  <= final_lev_d;
                    final_pend_q <= final_pend_d;
                    cnt_q        <= cnt_d;
                    lim_q        <= lim_d;
                    s_q          <= s_d;
                    busy_q       <= busy_d;
                    illegal_q    <= illegal_d;
                end
            end

            assign S_out[6*i +: 6] = s_q;
            assign busy[i]         = busy_q;
            assign illegal_req[i]  = illegal_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decoder_3lanpc_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3lanpc_multi
// Description : Directed self-checking bench for decoder_3lanpc_multi with
//               hand-computed gate sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3lanpc_multi;

    localparam int N_LEGS       = 3;
    localparam int TDELAY_WIDTH = 10;

    localparam logic [5:0] c_p   = 6'b100011;
    localparam logic [5:0] c_n   = 6'b011100;
    localparam logic [5:0] c_op  = 6'b010010;
    localparam logic [5:0] c_om  = 6'b100100;
    localparam logic [5:0] c_off = 6'b000000;

    logic                    clk;
    logic                    rst;
    logic [TDELAY_WIDTH-1:0] t_dead;
    logic [TDELAY_WIDTH-1:0] t_zmin;
    logic [2*N_LEGS-1:0]     v_lev;
    logic [N_LEGS-1:0]       zero_sel;
    logic                    trip;
    logic                    trip_clr;
    logic [6*N_LEGS-1:0]     S_out;
    logic [N_LEGS-1:0]       busy;
    logic                    faulted;
    logic [N_LEGS-1:0]       illegal_req;

    int checks = 0;
    int errors = 0;

    decoder_3lanpc_multi #(
        .N_LEGS       (N_LEGS),
        .TDELAY_WIDTH (TDELAY_WIDTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .t_dead      (t_dead),
        .t_zmin      (t_zmin),
        .v_lev       (v_lev),
        .zero_sel    (zero_sel),
        .trip        (trip),
        .trip_clr    (trip_clr),
        .S_out       (S_out),
        .busy        (busy),
        .faulted     (faulted),
        .illegal_req (illegal_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] leg(input int i);
        return S_out[6*i +: 6];
    endfunction

    // Advance n edges, expecting leg li to show pattern p and busy b each time.
    task automatic expect_seq(input string tag, input int li, input logic [5:0] p,
                              input int n, input logic b);
        for (int k = 0; k < n; k++) begin
            step();
            check({tag, "_s"}, {26'd0, leg(li)}, {26'd0, p});
            check({tag, "_b"}, {31'd0, busy[li]}, {31'd0, b});
        end
    endtask

    initial begin
        rst      = 1'b0;
        t_dead   = 10'd3;
        t_zmin   = 10'd5;
        v_lev    = 6'b000000;
        zero_sel = 3'b000;
        trip     = 1'b0;
        trip_clr = 1'b0;

        // 1. Reset, then all-off interval and landing on O+.
        repeat (4) step();
        check("rst_s",    {14'd0, S_out}, 32'd0);
        check("rst_busy", {29'd0, busy}, 32'd0);
        check("rst_flt",  {31'd0, faulted}, 32'd0);
        check("rst_ill",  {29'd0, illegal_req}, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rel_s",    {14'd0, S_out}, 32'd0);
            check("rel_busy", {29'd0, busy}, 32'd7);
        end
        step();
        check("rel_land", {14'd0, S_out}, {14'd0, c_op, c_op, c_op});
        check("rel_idle", {29'd0, busy}, 32'd0);

        // 2. Leg0 zero -> P, other legs untouched.
        v_lev = 6'b000001;
        expect_seq("zp_ov", 0, 6'b000010, 3, 1'b1);
        check("zp_l1", {26'd0, leg(1)}, {26'd0, c_op});
        check("zp_l2", {26'd0, leg(2)}, {26'd0, c_op});
        expect_seq("zp_land", 0, c_p, 1, 1'b0);

        // 3. Leg0 P -> N through a zero dwell.
        v_lev = 6'b000010;
        expect_seq("pn_d1", 0, 6'b000010, 3, 1'b1);
        expect_seq("pn_zd", 0, c_op,      5, 1'b1);
        expect_seq("pn_d2", 0, 6'b010000, 3, 1'b1);
        expect_seq("pn_land", 0, c_n,     1, 1'b0);

        // 4. Leg1 zero path O+ -> O-, then O- -> N.
        zero_sel = 3'b010;
        expect_seq("zs_ov", 1, c_off, 3, 1'b1);
        expect_seq("zs_land", 1, c_om, 1, 1'b0);
        v_lev = 6'b001010;
        expect_seq("on_ov", 1, 6'b000100, 3, 1'b1);
        expect_seq("on_land", 1, c_n, 1, 1'b0);

        // 5. Trip in the middle of leg2's dead interval.
        v_lev = 6'b011010;
        expect_seq("tr_pre", 2, 6'b000010, 1, 1'b1);
        trip  = 1'b1;
        v_lev = 6'b000000;
        step();
        check("tr_s",    {14'd0, S_out}, 32'd0);
        check("tr_flt",  {31'd0, faulted}, 32'd1);
        check("tr_busy", {29'd0, busy}, 32'd0);
        trip_clr = 1'b1;
        step();
        check("trc_hi_s",   {14'd0, S_out}, 32'd0);
        check("trc_hi_flt", {31'd0, faulted}, 32'd1);
        trip     = 1'b0;
        trip_clr = 1'b0;
        step();
        check("tr_hold_flt", {31'd0, faulted}, 32'd1);
        check("tr_hold_s",   {14'd0, S_out}, 32'd0);
        trip_clr = 1'b1;
        step();
        trip_clr = 1'b0;
        check("clr_flt",  {31'd0, faulted}, 32'd0);
        check("clr_s0",   {14'd0, S_out}, 32'd0);
        check("clr_busy", {29'd0, busy}, 32'd7);
        for (int k = 0; k < 2; k++) begin
            step();
            check("clr_s", {14'd0, S_out}, 32'd0);
        end
        step();
        check("clr_land", {14'd0, S_out}, {14'd0, c_op, c_om, c_op});
        check("clr_idle", {29'd0, busy}, 32'd0);
        step();
        check("clr_stay", {14'd0, S_out}, {14'd0, c_op, c_om, c_op});

        // 6a. Illegal request pulses and leaves the gates alone.
        v_lev = 6'b000011;
        step();
        check("ill_pulse", {29'd0, illegal_req}, 32'd1);
        check("ill_s",     {14'd0, S_out}, {14'd0, c_op, c_om, c_op});
        v_lev = 6'b000000;
        step();
        check("ill_clear", {29'd0, illegal_req}, 32'd0);
        check("ill_s2",    {14'd0, S_out}, {14'd0, c_op, c_om, c_op});

        // 6b. t_dead = 0 gives a single overlap cycle.
        t_dead = 10'd0;
        v_lev  = 6'b000001;
        expect_seq("td0_ov", 0, 6'b000010, 1, 1'b1);
        expect_seq("td0_land", 0, c_p, 1, 1'b0);

        // 6c. Request change during dead time: latched target completes first.
        t_dead = 10'd3;
        v_lev  = 6'b000000;
        expect_seq("chg_ov1", 0, 6'b000010, 1, 1'b1);
        v_lev  = 6'b000001;
        expect_seq("chg_ov2", 0, 6'b000010, 2, 1'b1);
        expect_seq("chg_land", 0, c_op, 1, 1'b0);
        expect_seq("chg_re", 0, 6'b000010, 3, 1'b1);
        expect_seq("chg_fin", 0, c_p, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_3lanpc_multi.md
Name: decoder_3lanpc_multi

Overview:
- Parametrised multi-leg successor to the single-leg 3-level ANPC decoder.
- Each of N_LEGS legs converts a 2-bit voltage-level request into 6 gate signals.
- Inserts dead-time using an overlap (AND) pattern, forces P<->N transitions through a zero state with a minimum dwell, and supports selectable upper/lower zero paths.
- A shared sticky trip input forces all gates off. Sits between the modulator and the gate-driver output pins.

Parameters:
N_LEGS, 3, number of independent phase legs
TDELAY_WIDTH, 10, width of timing inputs and per-leg counters

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
t_dead  in  TDELAY_WIDTH  dead/overlap interval in cycles; 0 treated as 1
t_zmin  in  TDELAY_WIDTH  minimum zero dwell on P<->N in cycles; 0 treated as 1
v_lev  in  2*N_LEGS  per-leg request: 00 zero, 01 P, 10 N, 11 illegal
zero_sel  in  N_LEGS  per-leg zero path: 0 = O+, 1 = O-
trip  in  1  fault; level-sensitive, all legs
trip_clr  in  1  clears fault latch
S_out  out  6*N_LEGS  leg i gates at [6i+5:6i] = {S6,S5,S4,S3,S2,S1}
busy  out  N_LEGS  leg in transition (DEAD or ZDWELL)
faulted  out  1  sticky fault flag
illegal_req  out  N_LEGS  1-cycle pulse on v_lev==11

Behaviour:
- Level patterns: P = 100011, N = 011100, O+ = 010010, O- = 100100. Zero pattern is chosen by zero_sel.
- Overlap pattern = pat(cur) AND pat(tgt).
- All outputs are registered. A request sampled at edge k first affects S_out after edge k (1-cycle latency).
- Per-leg FSM states: STEADY, DEAD, ZDWELL, FAULT. Per-leg registers: cur_lev, cur_zsel, tgt_lev, final_lev, cnt.
- STEADY:
  - S_out = pat(cur). busy = 0.
  - Transition starts if v_lev differs from cur_lev, or if cur_lev is zero and zero_sel differs from cur_zsel.
  - On start: tgt = requested level; for P<->N, tgt = zero and final = N/P. Go to DEAD, S_out = overlap, cnt = 0.
  - v_lev == 11: no transition, illegal_req pulses, cur is held.
- DEAD:
  - S_out = overlap for exactly max(t_dead,1) cycles.
  - Then S_out = pat(tgt) and cur = tgt (zero path latched at entry).
  - If final is pending, go to ZDWELL; else go to STEADY.
- ZDWELL:
  - Zero pattern held for max(t_zmin,1) cycles.
  - Then go to DEAD toward final (overlap of zero and final), then STEADY.
- Requests and zero_sel are ignored during DEAD/ZDWELL (target latched).
  - After landing, STEADY re-evaluates on the next cycle, so the minimum dwell at any level is 1 cycle.
  - A P->N request that reverts to P during ZDWELL still completes to N, then transitions back.
- busy = 1 in DEAD and ZDWELL.
- t_dead and t_zmin are sampled at each interval start; changes mid-interval have no effect.
- Trip (any state):
  - Next cycle: all S_out = 0, all legs go to FAULT, faulted = 1, busy = 0.
  - trip_clr with trip low: each leg enters DEAD with overlap = 000000, tgt = zero (per zero_sel), cur undefined. faulted clears on the same edge.
  - trip_clr with trip high is ignored. trip wins over trip_clr.
- Reset (rst = 0):
  - S_out = 0, busy = 0, faulted = 0, illegal_req = 0, cnt = 0.
  - Legs are held in DEAD with overlap 000000 and tgt = zero.
  - After release: S_out = 0 for max(t_dead,1) cycles, then the zero pattern, then STEADY.
  - Reset mid-transition aborts immediately, same values.
- Counters saturate and never wrap. Comparison is cnt == max(t,1) - 1.
- Legs are fully independent except for trip/trip_clr/rst.

Test Plan:
1. Reset: N_LEGS = 3, t_dead = 3, zero_sel = 000, rst low 4 cycles -> all legs S_out = 000000 for 3 cycles after release, then 010010; busy = 1 during those 3 cycles.
2. 0->P: v_lev[1:0] = 01 at edge k, t_dead = 3 -> leg0 S_out = 000010 at k+1..k+3, 100011 from k+4; other legs unchanged.
3. P->N direct: t_dead = 3, t_zmin = 5, zero_sel = 0 -> 000010 ×3, 010010 ×5, 010000 ×3, then 011100; busy high for 11 cycles.
4. Zero path swap: leg at O+, zero_sel 0->1 -> 000000 ×3, then 100100. Same with zero_sel = 1 and 0->N gives 000100 ×3, then 011100.
5. Trip mid-DEAD: trip at edge k -> all S_out = 000000 from k+1, faulted = 1. trip_clr while trip high is ignored. trip_clr after trip low -> 000000 ×3, then zero pattern; faulted = 0.
6. Edge cases: v_lev = 11 -> illegal_req 1-cycle pulse, S_out unchanged. t_dead = 0 -> overlap lasts 1 cycle. Request change during DEAD -> latched target completes first, new transition starts 1 cycle after landing.
